key_debounce_multi: RTL
=======================

// Module: key_debounce_multi
// PURPOSE
//  Parametrised N-channel push-button front end. Each channel is synchronised,
//  debounced and edge-detected on its own, so simultaneous presses are legal.
//  Each channel emits one-cycle press and release pulses plus long-press and
//  auto-repeat pulses. Sits between board key pins and UI/menu logic, which
//  consume single-cycle strobes only.
// PARAMETERS
//  KEY_NUM      5           number of independent key channels
//  ACTIVE_LOW   1           1: pin low = pressed; 0: pin high = pressed
//  DEBOUNCE_CYC 250_000     consecutive stable samples to accept a change (>=2)
//  LONG_CYC     50_000_000  held cycles after press acceptance to fire key_long
//  REPEAT_CYC   10_000_000  period of key_repeat after key_long (>=1)
//  REPEAT_EN    1           1: enable auto-repeat; 0: key_repeat tied 0
// PORTS
//  clk          in   1        system clock
//  rst_n        in   1        synchronous reset, active low
//  key_in       in   KEY_NUM  raw asynchronous key pins
//  key_state    out  KEY_NUM  debounced level, 1 = pressed
//  key_press    out  KEY_NUM  1-cycle pulse when press is accepted
//  key_release  out  KEY_NUM  1-cycle pulse when release is accepted
//  key_long     out  KEY_NUM  1-cycle pulse when hold reaches LONG_CYC
//  key_repeat   out  KEY_NUM  1-cycle pulse every REPEAT_CYC after key_long
// BEHAVIOUR
//  - Clocking: one clock, clk. Reset rst_n is synchronous and active low.
//  - Reset: all outputs 0. Synchronisers, counters and key_state clear to the
//    released state, whatever the pin level. Reset mid-hold discards the hold.
//  - Input stage: key_in passes a 2-flop synchroniser per bit. Polarity is then
//    normalised with ACTIVE_LOW, giving sample s (1 = pressed).
//  - Debounce counter (per channel), width $clog2(DEBOUNCE_CYC):
//    - When s == key_state, the counter holds 0.
//    - When s != key_state, the counter increments each cycle.
//    - Any cycle with s == key_state restarts the counter at 0.
//    - At cnt == DEBOUNCE_CYC-1 with s still differing: at that edge key_state
//      toggles, cnt returns to 0, and key_press (0->1) or key_release (1->0) is
//      high for exactly the next cycle.
//  - Latency: raw pin edge to pulse = 2 sync cycles + DEBOUNCE_CYC cycles.
//  - Glitch rule: a bounce shorter than DEBOUNCE_CYC samples produces no pulse
//    and no key_state change.
//  - Hold FSM per channel, states IDLE, HOLD, REPEAT:
//    - IDLE -> HOLD on accepted press; hold_cnt cleared.
//    - HOLD: hold_cnt increments. At hold_cnt == LONG_CYC-1: key_long pulses,
//      go to REPEAT (REPEAT_EN=1) or stay in HOLD with hold_cnt saturated, so
//      key_long fires once only.
//    - REPEAT: rep_cnt counts 0..REPEAT_CYC-1. key_repeat pulses on each wrap
//      to 0. The first repeat comes REPEAT_CYC cycles after key_long.
//    - Any state -> IDLE on accepted release. The release-cycle pulse is
//      key_release only; long/repeat pulses are never issued on that cycle.
//  - Simultaneous events: channels are fully independent. Any set of pulses on
//    different bits may coincide. On one bit, press and release never coincide.
//  - Counter widths: $clog2 of each max count. No wrap except rep_cnt.
// STRUCTURE
//  - Shared package key_pkg:
//    - hold-state encoding localparams (IDLE=2'd0, HOLD=2'd1, REPEAT=2'd2)
//    - clog2-width helper function for counter sizing
//  - Sub-module key_debounce_ch: one channel (sync, debounce, hold FSM, 5
//    outputs). The top instantiates KEY_NUM copies in a generate loop.
//  - All outputs are registered. No combinational path from key_in to outputs.
// TESTING (bench parameters: KEY_NUM=4, DEBOUNCE_CYC=4, LONG_CYC=20,
//          REPEAT_CYC=8, ACTIVE_LOW=1)
//  1 Reset with all pins low (pressed): outputs 0 during reset. After release of
//    rst_n, key_press=4'b1111 for 1 cycle at cycle 6; key_state=4'b1111.
//  2 key_in[0] bounces 1,0,1,0 (3 cycles each), then low steady: no pulse
//    during bounce. A single key_press[0] pulse 6 cycles after the last edge.
//  3 Hold key 1 for 50 cycles after acceptance: key_long[1] at +20 cycles,
//    key_repeat[1] at +28, +36, +44. Then release: key_release[1] once, and no
//    further repeat.
//  4 REPEAT_EN=0, hold 60 cycles: exactly one key_long. key_repeat stays 0.
//  5 Keys 2 and 3 pressed on the same cycle: key_press=4'b1100 in one cycle.
//    Key 3 released 10 cycles later: key_state[2] unaffected.
//  6 Assert rst_n=0 mid-REPEAT: all outputs 0 next cycle. Key still held after
//    reset: a fresh key_press, and key_long again after LONG_CYC.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the multi-channel key front end: hold-state encoding
// and counter sizing.
package key_pkg;

  localparam logic [1:0] HS_IDLE   = 2'd0;
  localparam logic [1:0] HS_HOLD   = 2'd1;
  localparam logic [1:0] HS_REPEAT = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = HS_IDLE,
    HOLD   = HS_HOLD,
    REPEAT = HS_REPEAT
  } hold_state_e;

  // Counter width for a 0..max_count-1 counter; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    if (max_count < 2) begin
      return 1;
    end
    return 32'($clog2(max_count));
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce, press/release strobes and a
// hold FSM producing long-press and auto-repeat strobes.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned ACTIVE_LOW   = 1,
  parameter int unsigned DEBOUNCE_CYC = 250_000,
  parameter int unsigned LONG_CYC     = 50_000_000,
  parameter int unsigned REPEAT_CYC   = 10_000_000,
  parameter int unsigned REPEAT_EN    = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic state_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int unsigned DW = cnt_width(DEBOUNCE_CYC);
  localparam int unsigned LW = cnt_width(LONG_CYC);
  localparam int unsigned RW = cnt_width(REPEAT_CYC);
  // Pin level that means "released"; synchroniser resets to it.
  localparam logic REL_LVL = (ACTIVE_LOW != 0);

  logic          sync1_q;
  logic          sync2_q;
  logic          state_q;
  logic          press_q;
  logic          release_q;
  logic          long_q;
  logic          repeat_q;
  logic          long_done_q;
  logic [DW-1:0] db_cnt_q;
  logic [LW-1:0] hold_cnt_q;
  logic [RW-1:0] rep_cnt_q;
  hold_state_e   hs_q;

  logic sample;
  logic differ;
  logic accept;
  logic accept_press;
  logic accept_release;

  assign sample         = sync2_q ^ REL_LVL;
  assign differ         = (sample != state_q);
  assign accept         = differ && (db_cnt_q == DW'(DEBOUNCE_CYC - 1));
  assign accept_press   = accept && !state_q;
  assign accept_release = accept && state_q;

  // Synchroniser and debounce: state flips after DEBOUNCE_CYC differing samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= REL_LVL;
      sync2_q   <= REL_LVL;
      state_q   <= 1'b0;
      db_cnt_q  <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= key_i;
      sync2_q   <= sync1_q;
      press_q   <= accept_press;
      release_q <= accept_release;
      if (accept) begin
        state_q  <= ~state_q;
        db_cnt_q <= '0;
      end else if (differ) begin
        db_cnt_q <= db_cnt_q + DW'(1);
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

  // Hold FSM; an accepted release wins over any long/repeat strobe that cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_q        <= IDLE;
      hold_cnt_q  <= '0;
      rep_cnt_q   <= '0;
      long_done_q <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      if (accept_release) begin
        hs_q        <= IDLE;
        hold_cnt_q  <= '0;
        rep_cnt_q   <= '0;
        long_done_q <= 1'b0;
      end else begin
        case (hs_q)
          IDLE: begin
            if (accept_press) begin
              hs_q        <= HOLD;
              hold_cnt_q  <= '0;
              long_done_q <= 1'b0;
            end
          end
          HOLD: begin
            if (!long_done_q) begin
              if (hold_cnt_q == LW'(LONG_CYC - 1)) begin
                long_q <= 1'b1;
                if (REPEAT_EN != 0) begin
                  hs_q      <= REPEAT;
                  rep_cnt_q <= '0;
                end else begin
                  long_done_q <= 1'b1;
                end
              end else begin
                hold_cnt_q <= hold_cnt_q + LW'(1);
              end
            end
          end
          REPEAT: begin
            if (rep_cnt_q == RW'(REPEAT_CYC - 1)) begin
              rep_cnt_q <= '0;
              repeat_q  <= 1'b1;
            end else begin
              rep_cnt_q <= rep_cnt_q + RW'(1);
            end
          end
          default: hs_q <= IDLE;
        endcase
      end
    end
  end

  assign state_o   = state_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_debounce_multi.sv
// N independent key channels; every output bit is a registered per-channel
// level or single-cycle strobe.
module key_debounce_multi #(
  parameter int unsigned KEY_NUM      = 5,
  parameter int unsigned ACTIVE_LOW   = 1,
  parameter int unsigned DEBOUNCE_CYC = 250_000,
  parameter int unsigned LONG_CYC     = 50_000_000,
  parameter int unsigned REPEAT_CYC   = 10_000_000,
  parameter int unsigned REPEAT_EN    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long,
  output logic [KEY_NUM-1:0] key_repeat
);

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_ch
    key_debounce_ch #(
      .ACTIVE_LOW  (ACTIVE_LOW),
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC),
      .REPEAT_CYC  (REPEAT_CYC),
      .REPEAT_EN   (REPEAT_EN)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_i    (key_in[g]),
      .state_o  (key_state[g]),
      .press_o  (key_press[g]),
      .release_o(key_release[g]),
      .long_o   (key_long[g]),
      .repeat_o (key_repeat[g])
    );
  end

endmodule
